// File: rtl/axis_xbar_port_arbiter.sv
// axis_xbar_port_arbiter: packet-granular round-robin grant for one cross-bar output port
module axis_xbar_port_arbiter #(
    parameter int PORT_NUM    = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                glb_clk,
    input  logic                glb_reset,
    input  logic                arb_en,
    input  logic [PORT_NUM-1:0] req,
    input  logic                out_tvalid,
    input  logic                out_tready,
    input  logic                out_tlast,
    output logic [PORT_NUM-1:0] fifo_sel_bits,
    output logic                busy,
    output logic                timeout_pulse,
    output logic [PORT_NUM-1:0] timeout_src,
    output logic [15:0]         pkt_cnt
);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PORT_NUM-1:0] ONE = PORT_NUM'(1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [PORT_NUM-1:0] last_ptr, ptr_nx, sel_nx, src_nx;
    logic [PORT_NUM-1:0] base, hi, masked, win;
    logic [WDW-1:0] wd_cnt, wd_nx;
    logic [15:0] cnt_nx;
    logic beat, eop, fire, pulse_nx;
    assign busy = (state == BUSY);
    // Round robin: first request strictly above the base pointer, else lowest request.
    // In BUSY the base is the current winner, so it only wins again when nobody else asks.
    always_comb begin
        base   = (state == BUSY) ? fifo_sel_bits : last_ptr;
        hi     = ~((base << 1) - ONE);
        masked = req & hi;
        win    = (|masked) ? (masked & (~masked + ONE)) : (req & (~req + ONE));
    end
    // Next-state, grant, watchdog and counter logic
    always_comb begin
        beat     = out_tvalid & out_tready;
        eop      = beat & out_tlast;
        fire     = (state == BUSY) && !beat && (wd_cnt == WDW'(TIMEOUT_CYC - 1));
        state_nx = state;
        sel_nx   = fifo_sel_bits;
        ptr_nx   = last_ptr;
        wd_nx    = wd_cnt;
        pulse_nx = 1'b0;
        src_nx   = timeout_src;
        cnt_nx   = pkt_cnt;
        if (state == IDLE) begin
            sel_nx = '0;
            wd_nx  = '0;
            if (arb_en && |req) begin
                sel_nx   = win;
                state_nx = BUSY;
            end
        end else if (eop) begin
            cnt_nx   = pkt_cnt + 16'd1;
            ptr_nx   = fifo_sel_bits;
            wd_nx    = '0;
            sel_nx   = (arb_en && |req) ? win : '0;
            state_nx = (arb_en && |req) ? BUSY : IDLE;
        end else if (fire) begin
            state_nx = IDLE;
            sel_nx   = '0;
            pulse_nx = 1'b1;
            src_nx   = fifo_sel_bits;
            ptr_nx   = fifo_sel_bits;
            wd_nx    = '0;
        end else begin
            wd_nx = beat ? '0 : wd_cnt + WDW'(1);
        end
    end
    // State and output registers
    always_ff @(posedge glb_clk) begin
        if (glb_reset) begin
            state         <= IDLE;
            fifo_sel_bits <= '0;
            last_ptr      <= ONE << (PORT_NUM - 1);
            wd_cnt        <= '0;
            timeout_pulse <= 1'b0;
            timeout_src   <= '0;
            pkt_cnt       <= '0;
        end else begin
            state         <= state_nx;
            fifo_sel_bits <= sel_nx;
            last_ptr      <= ptr_nx;
            wd_cnt        <= wd_nx;
            timeout_pulse <= pulse_nx;
            timeout_src   <= src_nx;
            pkt_cnt       <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_axis_xbar_port_arbiter.sv
// tb_axis_xbar_port_arbiter: scoreboard bench for the output-port arbiter
module tb_axis_xbar_port_arbiter;
  logic glb_clk = 1'b0, glb_reset, arb_en, out_tvalid, out_tready, out_tlast;
  logic [3:0] req, fifo_sel_bits, timeout_src;
  logic busy, timeout_pulse;
  logic [15:0] pkt_cnt;
  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic        busy;
    logic        pulse;
    logic [3:0]  src;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_chk = 0, n_pass = 0, n_pulse = 0;
  axis_xbar_port_arbiter #(.PORT_NUM(4), .TIMEOUT_CYC(8)) dut (
    .glb_clk(glb_clk), .glb_reset(glb_reset), .arb_en(arb_en), .req(req),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .fifo_sel_bits(fifo_sel_bits), .busy(busy), .timeout_pulse(timeout_pulse),
    .timeout_src(timeout_src), .pkt_cnt(pkt_cnt)
  );
  always #5 glb_clk = ~glb_clk;
  always @(posedge glb_clk) if (timeout_pulse) n_pulse++;
  task automatic tick();
    @(posedge glb_clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [3:0] s, input logic b, input logic p,
                     input logic [3:0] src, input logic [15:0] c);
    exp_t x;
    x.name = n; x.sel = s; x.busy = b; x.pulse = p; x.src = src; x.cnt = c;
    exp_q.push_back(x);
  endtask
  always @(negedge glb_clk) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (fifo_sel_bits === e.sel && busy === e.busy && timeout_pulse === e.pulse &&
          timeout_src === e.src && pkt_cnt === e.cnt)
        n_pass++;
      else
        $display("FAIL %s: got sel=%b busy=%b pulse=%b src=%b cnt=%0d, expected sel=%b busy=%b pulse=%b src=%b cnt=%0d",
                 e.name, fifo_sel_bits, busy, timeout_pulse, timeout_src, pkt_cnt,
                 e.sel, e.busy, e.pulse, e.src, e.cnt);
    end
  end
  initial begin
    logic [3:0] g;
    glb_reset = 1; arb_en = 0; req = 0; out_tvalid = 0; out_tready = 0; out_tlast = 0;
    tick(); tick();
    n_chk++;
    if (fifo_sel_bits === 4'b0000 && busy === 1'b0 && timeout_pulse === 1'b0 &&
        timeout_src === 4'b0000 && pkt_cnt === 16'd0)
      n_pass++;
    else
      $display("FAIL reset_direct: sel=%b busy=%b pulse=%b src=%b cnt=%0d",
               fifo_sel_bits, busy, timeout_pulse, timeout_src, pkt_cnt);
    chk("reset", 4'b0000, 0, 0, 4'b0000, 0);
    glb_reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", 4'b0000, 0, 0, 4'b0000, 0);
    end
    arb_en = 1; req = 4'b1111; out_tvalid = 1; out_tready = 1; out_tlast = 0;
    tick();
    chk("rr_first", 4'b0001, 1, 0, 4'b0000, 0);
    for (int p = 0; p < 5; p++) begin
      g = 4'b0001 << (p % 4);
      for (int b = 0; b < 3; b++) begin
        out_tlast = (b == 2);
        if (p == 4 && b == 2) req = 4'b0000;
        tick();
        if (b < 2) chk("rr_hold", g, 1, 0, 4'b0000, 16'(p));
        else if (p < 4) chk("rr_next", 4'b0001 << ((p + 1) % 4), 1, 0, 4'b0000, 16'(p + 1));
        else chk("rr_done", 4'b0000, 0, 0, 4'b0000, 16'd5);
      end
    end
    out_tvalid = 0; out_tlast = 0; req = 4'b0100;
    tick();
    chk("lock_grant", 4'b0100, 1, 0, 4'b0000, 5);
    req = 4'b0001; out_tvalid = 1;
    tick();
    chk("lock_hold", 4'b0100, 1, 0, 4'b0000, 5);
    out_tlast = 1;
    tick();
    chk("lock_switch", 4'b0001, 1, 0, 4'b0000, 6);
    req = 4'b0000;
    tick();
    chk("lock_idle", 4'b0000, 0, 0, 4'b0000, 7);
    req = 4'b0010; out_tready = 0; out_tlast = 0;
    tick();
    chk("wd_grant", 4'b0010, 1, 0, 4'b0000, 7);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wd_stall", 4'b0010, 1, 0, 4'b0000, 7);
    end
    req = 4'b0000;
    tick();
    chk("wd_fire", 4'b0000, 0, 1, 4'b0010, 7);
    tick();
    chk("wd_after", 4'b0000, 0, 0, 4'b0010, 7);
    req = 4'b0100;
    tick();
    chk("wd_eop_grant", 4'b0100, 1, 0, 4'b0010, 7);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wd_eop_stall", 4'b0100, 1, 0, 4'b0010, 7);
    end
    req = 4'b0000; out_tready = 1; out_tlast = 1;
    tick();
    chk("wd_eop_win", 4'b0000, 0, 0, 4'b0010, 8);
    req = 4'b1000; out_tlast = 0;
    tick();
    chk("en_grant", 4'b1000, 1, 0, 4'b0010, 8);
    arb_en = 0; req = 4'b1111;
    tick();
    chk("en_hold", 4'b1000, 1, 0, 4'b0010, 8);
    out_tlast = 1;
    tick();
    chk("en_release", 4'b0000, 0, 0, 4'b0010, 9);
    out_tlast = 0;
    tick();
    chk("en_off1", 4'b0000, 0, 0, 4'b0010, 9);
    tick();
    chk("en_off2", 4'b0000, 0, 0, 4'b0010, 9);
    arb_en = 1; req = 4'b0010;
    tick();
    chk("rst_grant", 4'b0010, 1, 0, 4'b0010, 9);
    tick();
    chk("rst_hold", 4'b0010, 1, 0, 4'b0010, 9);
    glb_reset = 1; req = 4'b1111;
    tick();
    chk("rst_mid", 4'b0000, 0, 0, 4'b0000, 0);
    glb_reset = 0;
    tick();
    chk("rst_src0", 4'b0001, 1, 0, 4'b0000, 0);
    out_tlast = 1;
    tick();
    chk("rst_next", 4'b0010, 1, 0, 4'b0000, 1);
    @(negedge glb_clk);
    #1;
    n_chk++;
    if (n_pulse == 1) n_pass++;
    else $display("FAIL wd_pulse_count: got %0d timeout pulses, expected 1", n_pulse);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_xbar_port_arbiter.md
# axis_xbar_port_arbiter

Packet-granular round-robin arbiter for one output (fifo-side) port of the AXI-Stream bus cross bar. One instance per output port watches which rx sources request that port and drives the port's one-hot `fifo_sel_bits` vector. It holds each grant from the first beat to the `tlast` beat of the packet, so packets never interleave. A watchdog releases a grant whose source stalls.

## Interface
- `PORT_NUM`, 4, number of rx sources; width of request and select vectors.
- `TIMEOUT_CYC`, 1023, number of consecutive no-handshake cycles in BUSY before a forced release; must be ≥1.
- `glb_clk`  in  1  single clock; all logic on its rising edge.
- `glb_reset`  in  1  synchronous, active-high reset.
- `arb_en`  in  1  allows new grants; has no effect on a packet already granted.
- `req`  in  PORT_NUM  bit i = rx source i has `tvalid` high with a packet for this output.
- `out_tvalid`  in  1  fifo-side `tvalid` of this output port, after the mux.
- `out_tready`  in  1  fifo-side `tready` of this output port.
- `out_tlast`  in  1  fifo-side `tlast` of this output port.
- `fifo_sel_bits`  out  PORT_NUM  registered one-hot grant, or all-zero; feeds the cross-bar select input.
- `busy`  out  1  high while in BUSY.
- `timeout_pulse`  out  1  one-cycle pulse on a forced release.
- `timeout_src`  out  PORT_NUM  one-hot source of the last forced release; holds until the next timeout.
- `pkt_cnt`  out  16  count of packets completed with `tlast`; wraps modulo 2^16.

## Operation
- **Beat**: `out_tvalid & out_tready`. **End of packet (EOP)**: a beat with `out_tlast` high.
- **States.** Two states, IDLE and BUSY.
- **IDLE**
  - `fifo_sel_bits` = 0.
  - If `arb_en` is high and `req` ≠ 0, select a winner, load `fifo_sel_bits` with it and go to BUSY.
- **BUSY**
  - `fifo_sel_bits` holds the winner.
  - On an EOP beat:
    - `pkt_cnt` increments.
    - The round-robin pointer moves to the current winner.
    - Re-arbitration happens in the same cycle over `req` with the current winner masked off. If `arb_en` is high and another source wins, load it and stay in BUSY; this gives zero dead cycles.
    - If no other source wins but `arb_en` is high and the current winner's `req` bit is still set, re-grant the same source.
    - Otherwise go to IDLE with `fifo_sel_bits` = 0.
- **Round robin**
  - `last_ptr` is one-hot. The search starts at the index `last_ptr`+1, runs upward and wraps modulo `PORT_NUM`.
  - The first set `req` bit wins.
  - Reset value of `last_ptr` is bit `PORT_NUM`-1, so source 0 has first priority after reset.
- **Watchdog**
  - `wd_cnt` has width clog2(`TIMEOUT_CYC`+1). It clears on entering BUSY and on every beat, and increments in BUSY on cycles without a beat.
  - When `wd_cnt` = `TIMEOUT_CYC`-1 and there is no beat in that cycle:
    - Go to IDLE and clear `fifo_sel_bits`.
    - Pulse `timeout_pulse` for one cycle.
    - Set `timeout_src` to the winner and move `last_ptr` to the winner.
    - Leave `pkt_cnt` unchanged.
    - Do not re-arbitrate in that cycle.
- **Boundary cases**
  - A `req` bit dropping while its source is granted does not release the grant; only an EOP beat or the watchdog releases it.
  - An EOP beat in the same cycle the watchdog would fire counts as an EOP; no timeout occurs.
  - `arb_en` falling during BUSY: the current packet completes, then the block goes to IDLE.
  - `pkt_cnt` wraps from 0xFFFF to 0.
  - With `PORT_NUM`=1, the block degenerates to a packet gate for the single source.
- **Reset.** `glb_reset` high at any time, including mid-packet, forces on the next edge:
  - IDLE, `fifo_sel_bits` = 0, `busy` = 0.
  - `timeout_pulse` = 0, `timeout_src` = 0, `pkt_cnt` = 0, `wd_cnt` = 0.
  - `last_ptr` = bit `PORT_NUM`-1.

## Timing
- Grant latency: `req` sampled high in IDLE at edge t → `fifo_sel_bits` valid after edge t, so the first beat can occur in cycle t+1.
- EOP beat in cycle t → next winner's select valid in cycle t+1 (no bubble); or all-zero in t+1 if there is no further request.
- `busy` equals (state == BUSY) and is registered alongside `fifo_sel_bits`.
- `timeout_pulse` is asserted in the cycle after the `TIMEOUT_CYC`-th consecutive idle BUSY cycle, coincident with `fifo_sel_bits` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset and idle:** hold `glb_reset` for 2 cycles, then drop it with `req`=0 → all outputs 0 and `busy`=0 for 10 cycles.
- **Fairness:** `PORT_NUM`=4, `req`=4'b1111 held, each packet 3 beats with `out_tready`=1 → grant order 0,1,2,3,0. Each grant lasts exactly 3 cycles with no gap, and `pkt_cnt`=5 after 15 beats.
- **Packet lock:** grant source 2, then drop `req[2]` mid-packet and raise `req[0]` → select stays 4'b0100 until the EOP beat, then becomes 4'b0001 the next cycle.
- **Watchdog:** `TIMEOUT_CYC`=8, grant source 1, hold `out_tready`=0 → `timeout_pulse` once, `timeout_src`=4'b0010 and select=0 after 8 stall cycles; `pkt_cnt` unchanged.
- **Enable and reset mid-packet:** drop `arb_en` during a packet from source 3 → packet completes, then select=0 despite `req`=4'b1111. Later, assert `glb_reset` mid-packet → select=0 next cycle and source 0 wins first after reset.
